// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game core: FSM states, hit-zone velocities, colours.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   // set_dy = 0 keeps the ball's current vertical direction; dy = 1 means moving down
   typedef struct packed {
      logic [2:0] vx;
      logic [2:0] vy;
      logic       set_dy;
      logic       dy;
   } zone_vel_t;

   localparam zone_vel_t ZONE_0 = '{vx: 3'd2, vy: 3'd2, set_dy: 1'b1, dy: 1'b0};
   localparam zone_vel_t ZONE_1 = '{vx: 3'd3, vy: 3'd1, set_dy: 1'b1, dy: 1'b0};
   localparam zone_vel_t ZONE_2 = '{vx: 3'd4, vy: 3'd0, set_dy: 1'b0, dy: 1'b0};
   localparam zone_vel_t ZONE_3 = '{vx: 3'd3, vy: 3'd1, set_dy: 1'b1, dy: 1'b1};
   localparam zone_vel_t ZONE_4 = '{vx: 3'd2, vy: 3'd2, set_dy: 1'b1, dy: 1'b1};

   localparam logic [2:0] SERVE_VX = 3'd4;

   localparam logic [2:0] COL_BALL   = 3'b111;
   localparam logic [2:0] COL_P1     = 3'b001;
   localparam logic [2:0] COL_P2     = 3'b100;
   localparam logic [2:0] COL_BORDER = 3'b010;
   localparam logic [2:0] COL_BG     = 3'b000;

   function automatic zone_vel_t zone_vel(input logic [2:0] zone);
      zone_vel_t v;
      case (zone)
         3'd0:    v = ZONE_0;
         3'd1:    v = ZONE_1;
         3'd2:    v = ZONE_2;
         3'd3:    v = ZONE_3;
         3'd4:    v = ZONE_4;
         default: v = ZONE_2;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/pong_if.sv
// Game-core bus: scan position, tick and encoder pulses in; pixel colour and score state out.
interface pong_if;
   logic        tick;
   logic [11:0] x;
   logic [11:0] y;
   logic        p1_up;
   logic        p1_down;
   logic        p2_up;
   logic        p2_down;
   logic        restart;
   logic [2:0]  color;
   logic [3:0]  score_1;
   logic [3:0]  score_2;
   logic        game_over;
   logic        winner;

   modport master (
      output tick, x, y, p1_up, p1_down, p2_up, p2_down, restart,
      input  color, score_1, score_2, game_over, winner
   );

   modport slave (
      input  tick, x, y, p1_up, p1_down, p2_up, p2_down, restart,
      output color, score_1, score_2, game_over, winner
   );
endinterface

// File: rtl/pong_paddle.sv
// One player's paddle: top-edge position register driven by encoder pulses, clamped to the frame.
module pong_paddle #(
   parameter int FRAME_H  = 480,
   parameter int PAD_H    = 60,
   parameter int PAD_STEP = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        up,
   input  logic        down,
   output logic [11:0] pos
);
   localparam logic [12:0] POS_MAX = 13'(FRAME_H - PAD_H);
   localparam logic [12:0] STEP    = 13'(PAD_STEP);
   localparam logic [11:0] POS_RST = 12'((FRAME_H - PAD_H) / 2);

   logic [11:0] pos_r;
   logic [11:0] pos_n;
   logic [12:0] pos_ext_s;

   // Next position: opposing pulses cancel, both directions saturate instead of wrapping
   always_comb begin
      pos_ext_s = {1'b0, pos_r};
      pos_n     = pos_r;
      if (up && !down) begin
         if (pos_ext_s < STEP) begin
            pos_n = 12'd0;
         end else begin
            pos_n = 12'(pos_ext_s - STEP);
         end
      end else if (down && !up) begin
         if (pos_ext_s + STEP > POS_MAX) begin
            pos_n = 12'(POS_MAX);
         end else begin
            pos_n = 12'(pos_ext_s + STEP);
         end
      end else begin
         pos_n = pos_r;
      end
   end

   // Position register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_r <= POS_RST;
      end else begin
         pos_r <= pos_n;
      end
   end

   assign pos = pos_r;

endmodule

// File: rtl/pong_engine.sv
// Pong game core: ball motion, paddle hit zones, scoring, serve/game-over sequencing, pixel colour.
// Build option PONG_SPEEDUP_EN: a rally counter adds 1 to vx on every 4th paddle hit (max 7).
module pong_engine
   import pong_pkg::*;
#(
   parameter int FRAME_W     = 640,
   parameter int FRAME_H     = 480,
   parameter int PAD_W       = 12,
   parameter int PAD_H       = 60,
   parameter int BALL_S      = 10,
   parameter int P1_X        = 13,
   parameter int P2_X        = 615,
   parameter int PAD_STEP    = 30,
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 60
) (
   input logic   CLOCK_25,
   input logic   RESET_N,
   pong_if.slave bus
);
   localparam logic signed [13:0] FW_S      = 14'(FRAME_W);
   localparam logic signed [13:0] FH_S      = 14'(FRAME_H);
   localparam logic signed [13:0] BS_S      = 14'(BALL_S);
   localparam logic signed [13:0] HB_S      = 14'(BALL_S / 2);
   localparam logic signed [13:0] P1_FACE_S = 14'(P1_X + PAD_W);
   localparam logic signed [13:0] P2_FACE_S = 14'(P2_X);
   localparam logic signed [12:0] PH_S      = 13'(PAD_H);
   localparam logic [12:0] ZONE_H   = 13'(PAD_H / 5);
   localparam logic [11:0] CX       = 12'((FRAME_W - BALL_S) / 2);
   localparam logic [11:0] CY       = 12'((FRAME_H - BALL_S) / 2);
   localparam logic [11:0] P1_HIT_X = 12'(P1_X + PAD_W);
   localparam logic [11:0] P2_HIT_X = 12'(P2_X - BALL_S);
   localparam logic [11:0] FW_U = 12'(FRAME_W);
   localparam logic [11:0] FH_U = 12'(FRAME_H);
   localparam logic [11:0] BW_U = 12'(BALL_S);
   localparam logic [11:0] PW_U = 12'(PAD_W);
   localparam logic [11:0] PH_U = 12'(PAD_H);
   localparam logic [11:0] P1_U = 12'(P1_X);
   localparam logic [11:0] P2_U = 12'(P2_X);
   localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
   localparam int SC_W = $clog2(SERVE_TICKS + 1);
   localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_TICKS - 1);

   state_t state_r, state_n;
   logic [11:0] bx_r, by_r, bx_n, by_n;
   logic [2:0]  vx_r, vy_r, vx_n, vy_n;
   logic        dx_r, dy_r, dx_n, dy_n;     // dx 1: toward player 2, dy 1: down
   logic [SC_W-1:0] serve_cnt_r, serve_cnt_n;
   logic        serve_dir_r, serve_dir_n;
   logic [3:0]  score1_r, score2_r, score1_n, score2_n;
   logic        winner_r, winner_n, game_over_r;
   logic [2:0]  color_r, color_s;
   logic [11:0] pad1_y_s, pad2_y_s;
   logic signed [13:0] nx_s, ny_s, nxc_s, nyc_s;
   logic signed [12:0] off1_s, off2_s;
   logic [12:0] off_u_s;
   logic        top_s, bot_s, hit1_s, hit2_s, wall_dy_s, hit_dy_s;
   logic [2:0]  hit_vx_s;
   zone_vel_t   zv_s;
   logic        in_ball_s, in_p1_s, in_p2_s, border_s;
`ifdef PONG_SPEEDUP_EN
   logic [4:0]  rally_r, rally_n, rally_hit_s;
   logic [3:0]  vx_sum_s;
`endif

   pong_paddle #(.FRAME_H(FRAME_H), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad1 (
      .clk(CLOCK_25), .rst_n(RESET_N), .up(bus.p1_up), .down(bus.p1_down), .pos(pad1_y_s));
   pong_paddle #(.FRAME_H(FRAME_H), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad2 (
      .clk(CLOCK_25), .rst_n(RESET_N), .up(bus.p2_up), .down(bus.p2_down), .pos(pad2_y_s));

   // Candidate move for this tick: wall reflection, clamping and paddle zone lookup
   always_comb begin
      nx_s  = dx_r ? signed'({2'b00, bx_r}) + signed'({11'd0, vx_r})
                   : signed'({2'b00, bx_r}) - signed'({11'd0, vx_r});
      ny_s  = dy_r ? signed'({2'b00, by_r}) + signed'({11'd0, vy_r})
                   : signed'({2'b00, by_r}) - signed'({11'd0, vy_r});
      top_s = (ny_s <= 14'sd0);
      bot_s = (ny_s + BS_S >= FH_S);
      if (nx_s < 14'sd0) nxc_s = 14'sd0;
      else if (nx_s > FW_S - BS_S) nxc_s = FW_S - BS_S;
      else nxc_s = nx_s;
      if (ny_s < 14'sd0) nyc_s = 14'sd0;
      else if (ny_s > FH_S - BS_S) nyc_s = FH_S - BS_S;
      else nyc_s = ny_s;
      off1_s    = 13'(nyc_s + HB_S - signed'({2'b00, pad1_y_s}));
      off2_s    = 13'(nyc_s + HB_S - signed'({2'b00, pad2_y_s}));
      hit1_s    = (off1_s >= 13'sd0) && (off1_s < PH_S);
      hit2_s    = (off2_s >= 13'sd0) && (off2_s < PH_S);
      off_u_s   = dx_r ? $unsigned(off2_s) : $unsigned(off1_s);
      zv_s      = zone_vel(3'(off_u_s / ZONE_H));
      wall_dy_s = top_s ? 1'b1 : (bot_s ? 1'b0 : dy_r);
      hit_dy_s  = top_s ? 1'b1 : (bot_s ? 1'b0 : (zv_s.set_dy ? zv_s.dy : dy_r));
`ifdef PONG_SPEEDUP_EN
      rally_hit_s = (rally_r == 5'd31) ? rally_r : rally_r + 5'd1;
      vx_sum_s    = {1'b0, zv_s.vx} + {1'b0, rally_hit_s[4:2]};
      hit_vx_s    = (vx_sum_s > 4'd7) ? 3'd7 : vx_sum_s[2:0];
`else
      hit_vx_s    = zv_s.vx;
`endif
   end

   // Next-state logic: serve countdown, rally outcome, scoring and restart
   always_comb begin
      state_n = state_r;  bx_n = bx_r;  by_n = by_r;  vx_n = vx_r;  vy_n = vy_r;
      dx_n = dx_r;  dy_n = dy_r;  serve_cnt_n = serve_cnt_r;  serve_dir_n = serve_dir_r;
      score1_n = score1_r;  score2_n = score2_r;  winner_n = winner_r;
`ifdef PONG_SPEEDUP_EN
      rally_n = rally_r;
`endif
      case (state_r)
         ST_SERVE: begin
            if (bus.tick) begin
               bx_n = CX;  by_n = CY;  vx_n = SERVE_VX;  vy_n = 3'd0;  dx_n = serve_dir_r;
`ifdef PONG_SPEEDUP_EN
               rally_n = 5'd0;
`endif
               if (serve_cnt_r == SERVE_LAST) begin
                  state_n = ST_PLAY;  serve_cnt_n = '0;
               end else begin
                  serve_cnt_n = serve_cnt_r + SC_W'(1);
               end
            end else begin
               serve_cnt_n = serve_cnt_r;
            end
         end
         ST_PLAY: begin
            if (bus.tick) begin
               bx_n = 12'(nxc_s);  by_n = 12'(nyc_s);  dy_n = wall_dy_s;
               if ((!dx_r && nx_s <= P1_FACE_S && hit1_s) ||
                   (dx_r && nx_s + BS_S >= P2_FACE_S && hit2_s)) begin
                  bx_n = dx_r ? P2_HIT_X : P1_HIT_X;
                  dx_n = !dx_r;  vx_n = hit_vx_s;  vy_n = zv_s.vy;  dy_n = hit_dy_s;
`ifdef PONG_SPEEDUP_EN
                  rally_n = rally_hit_s;
`endif
               end else if ((!dx_r && nx_s <= P1_FACE_S) || (dx_r && nx_s + BS_S >= P2_FACE_S)) begin
                  // Miss: the opponent scores; the next serve goes toward whoever conceded
                  score1_n = dx_r ? score1_r + 4'd1 : score1_r;
                  score2_n = dx_r ? score2_r : score2_r + 4'd1;
                  if ((dx_r ? score1_n : score2_n) == WIN) begin
                     state_n = ST_OVER;  winner_n = !dx_r;
                  end else begin
                     state_n = ST_SERVE;  serve_dir_n = dx_r;  serve_cnt_n = '0;
                     bx_n = CX;  by_n = CY;  vx_n = SERVE_VX;  vy_n = 3'd0;  dx_n = dx_r;
`ifdef PONG_SPEEDUP_EN
                     rally_n = 5'd0;
`endif
                  end
               end else begin
                  state_n = ST_PLAY;
               end
            end else begin
               state_n = ST_PLAY;
            end
         end
         ST_OVER: begin
            if (bus.restart) begin
               state_n = ST_SERVE;  score1_n = 4'd0;  score2_n = 4'd0;
               serve_dir_n = 1'b1;  serve_cnt_n = '0;
            end else begin
               state_n = ST_OVER;
            end
         end
         default: state_n = ST_SERVE;
      endcase
   end

   // Pixel colour for the current scan position, by priority
   always_comb begin
      in_ball_s = (bus.x >= bx_r) && (bus.x < bx_r + BW_U) && (bus.y >= by_r) && (bus.y < by_r + BW_U);
      in_p1_s   = (bus.x >= P1_U) && (bus.x < P1_U + PW_U) && (bus.y >= pad1_y_s) && (bus.y < pad1_y_s + PH_U);
      in_p2_s   = (bus.x >= P2_U) && (bus.x < P2_U + PW_U) && (bus.y >= pad2_y_s) && (bus.y < pad2_y_s + PH_U);
      border_s  = (bus.x == 12'd0) || (bus.x == FW_U - 12'd1) || (bus.y == 12'd0) || (bus.y == FH_U - 12'd1);
      if (bus.x >= FW_U || bus.y >= FH_U) color_s = COL_BG;
      else if (in_ball_s) color_s = COL_BALL;
      else if (in_p1_s)   color_s = COL_P1;
      else if (in_p2_s)   color_s = COL_P2;
      else if (border_s)  color_s = COL_BORDER;
      else                color_s = COL_BG;
   end

   // State registers
   always_ff @(posedge CLOCK_25) begin
      if (!RESET_N) begin
         state_r <= ST_SERVE;  bx_r <= CX;  by_r <= CY;  vx_r <= SERVE_VX;  vy_r <= 3'd0;
         dx_r <= 1'b1;  dy_r <= 1'b1;  serve_cnt_r <= '0;  serve_dir_r <= 1'b1;
         score1_r <= 4'd0;  score2_r <= 4'd0;  winner_r <= 1'b0;  game_over_r <= 1'b0;
         color_r <= COL_BG;
`ifdef PONG_SPEEDUP_EN
         rally_r <= 5'd0;
`endif
      end else begin
         state_r <= state_n;  bx_r <= bx_n;  by_r <= by_n;  vx_r <= vx_n;  vy_r <= vy_n;
         dx_r <= dx_n;  dy_r <= dy_n;  serve_cnt_r <= serve_cnt_n;  serve_dir_r <= serve_dir_n;
         score1_r <= score1_n;  score2_r <= score2_n;  winner_r <= winner_n;
         game_over_r <= (state_n == ST_OVER);
         color_r <= color_s;
`ifdef PONG_SPEEDUP_EN
         rally_r <= rally_n;
`endif
      end
   end

   assign bus.color     = color_r;
   assign bus.score_1   = score1_r;
   assign bus.score_2   = score2_r;
   assign bus.game_over = game_over_r;
   assign bus.winner    = winner_r;

endmodule
